// File: rtl/mux_lane_scheduler.sv
// Round-robin burst scheduler sharing one registered output lane among four buffered input lanes.
// Optional build macro SCHED_FIXED_PRIO_EN selects fixed priority (lane 0 highest) instead.
module mux_lane_scheduler #(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned BURST_LEN = 4,
  parameter int unsigned CNT_W     = 3
) (
  input  logic              clk_4f,
  input  logic              reset,
  input  logic              validEntrada0,
  input  logic              validEntrada1,
  input  logic              validEntrada2,
  input  logic              validEntrada3,
  input  logic [DATA_W-1:0] Entrada0,
  input  logic [DATA_W-1:0] Entrada1,
  input  logic [DATA_W-1:0] Entrada2,
  input  logic [DATA_W-1:0] Entrada3,
  output logic              readyEntrada0,
  output logic              readyEntrada1,
  output logic              readyEntrada2,
  output logic              readyEntrada3,
  output logic [DATA_W-1:0] Salida,
  output logic              validSalida,
  input  logic              readySalida,
  output logic [1:0]        lane_id
);

  typedef enum logic [0:0] {StIdle, StBurst} state_e;

  localparam logic [CNT_W-1:0] LastBeat = CNT_W'(BURST_LEN - 1);

  state_e                  state_q, state_d;
  logic [1:0]              g_q, g_d;
  logic [1:0]              last_q, last_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [3:0]              full_q, full_d;
  logic [3:0][DATA_W-1:0]  hold_q, hold_d;
  logic [DATA_W-1:0]       salida_q, salida_d;
  logic                    vout_q, vout_d;
  logic [1:0]              lane_q, lane_d;

  logic [3:0]              valid_in;
  logic [3:0][DATA_W-1:0]  data_in;
  logic [3:0]              ready;
  logic                    out_free;
  logic                    load;
  logic [1:0]              pick;

  assign valid_in = {validEntrada3, validEntrada2, validEntrada1, validEntrada0};
  assign data_in  = {Entrada3, Entrada2, Entrada1, Entrada0};

`ifdef SCHED_FIXED_PRIO_EN
  always_comb begin
    pick = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (full_q[i]) pick = 2'(i);
    end
  end
`else
  // Search starts just after the lane that owned the previous burst.
  always_comb begin
    logic       found;
    logic [1:0] idx;
    pick  = last_q;
    found = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      idx = last_q + 2'(i);
      if (!found && full_q[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
  end
`endif

  // State register and datapath registers.
  always_ff @(posedge clk_4f) begin
    if (!reset) begin
      state_q  <= StIdle;
      g_q      <= 2'd0;
      last_q   <= 2'd3;
      cnt_q    <= '0;
      full_q   <= '0;
      hold_q   <= '0;
      salida_q <= '0;
      vout_q   <= 1'b0;
      lane_q   <= 2'd0;
    end else begin
      state_q  <= state_d;
      g_q      <= g_d;
      last_q   <= last_d;
      cnt_q    <= cnt_d;
      full_q   <= full_d;
      hold_q   <= hold_d;
      salida_q <= salida_d;
      vout_q   <= vout_d;
      lane_q   <= lane_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    g_d     = g_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    case (state_q)
      StIdle: begin
        if (|full_q) begin
          g_d     = pick;
          cnt_d   = '0;
          state_d = StBurst;
        end
      end
      StBurst: begin
        if (load) begin
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == LastBeat) begin
            state_d = StIdle;
            last_d  = g_q;
          end
        end else if (!full_q[g_q]) begin
          state_d = StIdle;
          last_d  = g_q;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs: handshake decode and output-stage transfer.
  always_comb begin
    out_free = ~vout_q | readySalida;
    load     = (state_q == StBurst) & full_q[g_q] & out_free;
    for (int n = 0; n < 4; n++) begin
      ready[n] = reset & (~full_q[n] | (load & (g_q == 2'(n))));
    end
  end

  // Granted lane may drain and refill in the same cycle.
  always_comb begin
    full_d   = full_q;
    hold_d   = hold_q;
    salida_d = salida_q;
    lane_d   = lane_q;
    vout_d   = vout_q;
    for (int n = 0; n < 4; n++) begin
      if (valid_in[n] && ready[n]) begin
        hold_d[n] = data_in[n];
        full_d[n] = 1'b1;
      end else if (load && (g_q == 2'(n))) begin
        full_d[n] = 1'b0;
      end
    end
    if (load) begin
      salida_d = hold_q[g_q];
      lane_d   = g_q;
      vout_d   = 1'b1;
    end else if (readySalida) begin
      vout_d = 1'b0;
    end
  end

  assign readyEntrada0 = ready[0];
  assign readyEntrada1 = ready[1];
  assign readyEntrada2 = ready[2];
  assign readyEntrada3 = ready[3];
  assign Salida        = salida_q;
  assign validSalida   = vout_q;
  assign lane_id       = lane_q;

endmodule

// File: tb/tb_mux_lane_scheduler.sv
// Scoreboard bench for mux_lane_scheduler: directed lane traffic, expected words queued up front.
module tb_mux_lane_scheduler;

  logic            clk_4f = 1'b0;
  logic            reset  = 1'b0;
  logic [3:0]      vin;
  logic [3:0][7:0] din;
  logic [3:0]      rdy;
  logic [7:0]      salida;
  logic            vout;
  logic            rout = 1'b1;
  logic [1:0]      lid;

  always #5 clk_4f = ~clk_4f;

  mux_lane_scheduler #(.DATA_W(8), .BURST_LEN(4), .CNT_W(3)) dut (
    .clk_4f        (clk_4f),
    .reset         (reset),
    .validEntrada0 (vin[0]),
    .validEntrada1 (vin[1]),
    .validEntrada2 (vin[2]),
    .validEntrada3 (vin[3]),
    .Entrada0      (din[0]),
    .Entrada1      (din[1]),
    .Entrada2      (din[2]),
    .Entrada3      (din[3]),
    .readyEntrada0 (rdy[0]),
    .readyEntrada1 (rdy[1]),
    .readyEntrada2 (rdy[2]),
    .readyEntrada3 (rdy[3]),
    .Salida        (salida),
    .validSalida   (vout),
    .readySalida   (rout),
    .lane_id       (lid)
  );

  typedef struct packed {
    logic [1:0] lane;
    logic [7:0] data;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_chk = 0;
  int   n_fail = 0;
  int   npop = 0;
  int   cyc = 0;
  int   first_cyc = 0;
  int   last_cyc = 0;
  bit   mon_en = 1'b1;

  int       src_left[4] = '{0, 0, 0, 0};
  bit [7:0] src_data[4] = '{0, 0, 0, 0};
  bit       src_inc[4]  = '{0, 0, 0, 0};

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic exp_push(input int lane, input int data);
    sb.push_back({2'(lane), 8'(data)});
  endtask

  task automatic step();
    @(negedge clk_4f);
    #1;
  endtask

  task automatic at_pos();
    @(posedge clk_4f);
    #1;
  endtask

  task automatic do_reset();
    at_pos();
    reset = 1'b0;
    at_pos();
    at_pos();
    reset = 1'b1;
  endtask

  task automatic wait_empty(input int budget, input string name);
    int k;
    k = 0;
    while (sb.size() != 0 && k < budget) begin
      step();
      k++;
    end
    if (sb.size() != 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL %s timeout: %0d words outstanding, want 0", name, sb.size());
    end
  endtask

  // Lane sources: each handshake consumes one word; optional incrementing data.
  initial begin
    bit [3:0] hs;
    vin = '0;
    din = '0;
    forever begin
      @(negedge clk_4f);
      hs = vin & rdy;
      @(posedge clk_4f);
      #1;
      for (int n = 0; n < 4; n++) begin
        if (hs[n]) begin
          src_left[n]--;
          if (src_inc[n]) src_data[n]++;
        end
        vin[n] = (src_left[n] > 0);
        din[n] = src_data[n];
      end
    end
  end

  // Monitor: a word is consumed at the edge following a negedge with valid & ready.
  always @(negedge clk_4f) begin
    cyc++;
    if (mon_en && reset && vout && rout) begin
      npop++;
      if (npop == 1) first_cyc = cyc;
      last_cyc = cyc;
      if (sb.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_out: got lane %0d data 0x%0h, want none", lid, salida);
      end else begin
        mon_e = sb.pop_front();
        chk("out_lane", int'(lid), int'(mon_e.lane));
        chk("out_data", int'(salida), int'(mon_e.data));
      end
    end
  end

  initial begin
    int k;
    // Reset with all lanes offering data.
    for (int n = 0; n < 4; n++) begin
      src_left[n] = 1000;
      src_data[n] = 8'(8'h10 + n);
      src_inc[n]  = 1'b0;
    end
    repeat (3) step();
    chk("rst_ready", int'(rdy), 0);
    chk("rst_valid", int'(vout), 0);
    chk("rst_salida", int'(salida), 0);
    chk("rst_lane", int'(lid), 0);
    for (int n = 0; n < 4; n++) src_left[n] = 0;
    at_pos();
    at_pos();
    reset = 1'b1;
    step();
    chk("rel_ready", int'(rdy), 4'hf);

    // Single word latency on lane 2.
    src_left[2] = 1;
    src_data[2] = 8'hA5;
    exp_push(2, 8'hA5);
    at_pos();
    @(posedge clk_4f);
    step();
    chk("lat_e0_valid", int'(vout), 0);
    chk("lat_e0_ready2", int'(rdy[2]), 0);
    step();
    chk("lat_e1_valid", int'(vout), 0);
    step();
    chk("lat_e2_valid", int'(vout), 1);
    step();
    chk("lat_e3_valid", int'(vout), 0);
    wait_empty(20, "single");

    // All lanes continuously valid: 5 bursts of 4 with one bubble between.
    do_reset();
    step();
    npop = 0;
    for (int b = 0; b < 5; b++) begin
`ifdef SCHED_FIXED_PRIO_EN
      repeat (4) exp_push(0, 8'h10);
`else
      repeat (4) exp_push(b % 4, 8'h10 + (b % 4));
`endif
    end
    for (int n = 0; n < 4; n++) begin
      src_left[n] = 1000;
      src_data[n] = 8'(8'h10 + n);
      src_inc[n]  = 1'b0;
    end
    wait_empty(200, "rr");
    chk("rr_span", last_cyc - first_cyc, 23);
    mon_en = 1'b0;
    for (int n = 0; n < 4; n++) src_left[n] = 0;
    do_reset();
    at_pos();
    sb.delete();
    mon_en = 1'b1;

    // Backpressure mid-burst on lane 0.
    step();
    npop = 0;
    for (int i = 0; i < 8; i++) exp_push(0, 8'h40 + i);
    src_data[0] = 8'h40;
    src_inc[0]  = 1'b1;
    src_left[0] = 8;
    k = 0;
    while (npop < 2 && k < 50) begin
      step();
      k++;
    end
    chk("stall_reach", npop, 2);
    at_pos();
    rout = 1'b0;
    repeat (5) begin
      step();
      chk("stall_salida", int'(salida), 8'h42);
      chk("stall_lane", int'(lid), 0);
      chk("stall_valid", int'(vout), 1);
      chk("stall_ready0", int'(rdy[0]), 0);
    end
    at_pos();
    rout = 1'b1;
    wait_empty(100, "stall");
    src_inc[0] = 1'b0;

    // Short lane 1 burst, then pending lane 3.
    do_reset();
    step();
    npop = 0;
    exp_push(1, 8'h21);
    exp_push(1, 8'h22);
    exp_push(3, 8'h3C);
    src_data[1] = 8'h21;
    src_inc[1]  = 1'b1;
    src_left[1] = 2;
    src_data[3] = 8'h3C;
    src_left[3] = 1;
    wait_empty(50, "early_end");
    chk("early_span", last_cyc - first_cyc, 4);
    src_inc[1] = 1'b0;

    // Reset during a lane 1 burst with every lane full.
    do_reset();
    mon_en = 1'b0;
    step();
    for (int n = 0; n < 4; n++) begin
      src_left[n] = 1000;
      src_data[n] = 8'(8'h10 + n);
    end
    k = 0;
`ifdef SCHED_FIXED_PRIO_EN
    while (!(vout && lid == 2'd0) && k < 100) begin
`else
    while (!(vout && lid == 2'd1) && k < 100) begin
`endif
      step();
      k++;
    end
    chk("midrst_reach", int'(k < 100), 1);
    for (int n = 0; n < 4; n++) src_left[n] = 0;
    at_pos();
    reset = 1'b0;
    step();
    chk("midrst_ready", int'(rdy), 0);
    step();
    chk("midrst_valid", int'(vout), 0);
    chk("midrst_salida", int'(salida), 0);
    chk("midrst_lane", int'(lid), 0);
    at_pos();
    at_pos();
    reset = 1'b1;
    sb.delete();
    mon_en = 1'b1;
    step();
    exp_push(0, 8'h50);
    exp_push(1, 8'h51);
    src_data[0] = 8'h50;
    src_left[0] = 1;
    src_data[1] = 8'h51;
    src_left[1] = 1;
    wait_empty(50, "post_reset");

    repeat (5) step();
    chk("sb_drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mux_lane_scheduler.md
Name: mux_lane_scheduler

Overview:
Round-robin burst scheduler that shares one 8-bit output lane among the four input lanes (Entrada0..3) feeding the mux tree. Each lane has a 1-entry holding register with valid/ready handshake. The scheduler grants one lane at a time for bursts of up to BURST_LEN words into a registered output stage with downstream backpressure. It replaces the free-running clk_f/clk_2f selection with demand-driven sequencing in the clk_4f domain.

Parameters:
DATA_W, 8, width of every data lane
BURST_LEN, 4, max words per grant (>=1)
CNT_W, 3, beat counter width; must hold BURST_LEN-1

Ports:
clk_4f  input  1  sole clock, all state on rising edge
reset  input  1  synchronous, active-low reset
validEntrada0..validEntrada3  input  1 each  lane N word valid
Entrada0..Entrada3  input  DATA_W each  lane N data
readyEntrada0..readyEntrada3  output  1 each  lane N can accept this cycle
Salida  output  DATA_W  scheduled output word (registered)
validSalida  output  1  Salida valid (registered)
readySalida  input  1  downstream accepts Salida
lane_id  output  2  source lane of Salida (registered)

Behaviour:
- Reset (reset==0 at edge): full[3:0]=0, Salida=0, validSalida=0, lane_id=0, state=IDLE, cnt=0, last=3. While reset==0, all readyEntradaN forced 0. Held words are discarded.
- Definitions: out_free = ~validSalida | readySalida. load = (state==BURST) & full[g] & out_free.
- readyEntradaN = reset & (~full[N] | (load & g==N)) (combinational). Same-cycle drain and refill of the granted lane is allowed, giving 1 word/cycle sustained.
- Accept: validEntradaN & readyEntradaN -> hold[N] <= EntradaN, full[N] <= 1. Drain without refill -> full[N] <= 0.
- FSM IDLE:
  - If any full: g <= first full lane in order last+1, last+2, last+3, last (mod 4); cnt <= 0; -> BURST.
  - No data moves in IDLE.
- FSM BURST:
  - On load: Salida <= hold[g], lane_id <= g, validSalida <= 1, cnt <= cnt+1. If cnt==BURST_LEN-1: -> IDLE, last <= g.
  - If ~full[g]: early end. -> IDLE, last <= g, no load.
  - If full[g] & ~out_free: stall. Hold state, cnt, Salida, lane_id.
- Output clear: validSalida <= 0 when readySalida & ~load. Salida and lane_id retain their last values.
- Latency: word accepted at edge E0 into an idle scheduler -> grant at E1 -> validSalida high after E2.
- Burst boundary: one IDLE bubble cycle between bursts.
- Ungranted lanes hold their word, and readyEntrada stays 0 until drained. No loss, no duplication.
- Reset mid-burst: takes effect at that edge regardless of state. Next grant starts search at lane 0.

Optional Feature:
SCHED_FIXED_PRIO_EN
- Defined: IDLE selects the lowest-index full lane (fixed priority, lane 0 highest); last is not used. BURST behaviour is unchanged.
- Undefined: round-robin as specified above.

Test Plan:
- Hold reset=0 for 2 cycles with all validEntrada=1 -> readyEntrada0..3=0, validSalida=0, Salida=0x00. After release -> readyEntrada=1111.
- Lane2 pushes 0xA5 once, readySalida=1 -> validSalida=1 for exactly one cycle, 2 edges after accept, with Salida=0xA5 and lane_id=2.
- All lanes continuously valid, data 0x10+N, BURST_LEN=4, readySalida=1 -> 4 words from lane0, 1 bubble, 4 from lane1, then lane2, lane3, lane0. With SCHED_FIXED_PRIO_EN -> lane0 only.
- readySalida=0 for 5 cycles mid-burst -> Salida, lane_id and validSalida stable; readyEntrada of full lanes =0. After release the sequence continues with no dropped or repeated word.
- Lane1 sends 2 words then deasserts, lane3 pending -> 2 words lane_id=1, IDLE bubble, then lane3 word.
- Assert reset during a lane1 burst with all lanes full -> outputs cleared next edge. After release, push lane0 and lane1 -> lane0 is granted first.
